// File: rtl/clock_ui_pkg.sv
// -----------------------------------------------------------------------------
// clock_ui_pkg
//
// Shared definitions for the clock user-interface blocks. It holds the default
// timing values for button debounce and auto-repeat, the encoding of the
// auto-repeat state, and a helper that keeps pulse spacing at two cycles or
// more.
//
// No ports (package).
// -----------------------------------------------------------------------------
package clock_ui_pkg;

    // Default timing, in system clock cycles.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int REPEAT_DELAY_DEFAULT    = 25000000;
    localparam int REPEAT_PERIOD_DEFAULT   = 5000000;

    // Auto-repeat state of a held up/down button.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } repeat_state_e;

    // Two pulses on one output must have at least one low cycle between them.
    // Any spacing below 2 is therefore raised to 2.
    function automatic int minSpacing(input int cycles);
        return (cycles < 2) ? 2 : cycles;
    endfunction

endpackage

// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//
// Conditions one raw push-button input. The input passes through a two-flop
// synchronizer and a debounce counter. A registered one-cycle rise pulse marks
// each accepted press.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-high reset
//   raw_i   - asynchronous, bouncing button input (high = pressed)
//   level_o - debounced button level
//   rise_o  - high for one cycle, in the same cycle that level_o first goes high
// -----------------------------------------------------------------------------
module debouncer
    import clock_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    // Value the counter holds on the edge where it would reach DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    // The counter runs only while the synchronized input disagrees with the
    // debounced level. Any agreement, such as a bounce back, restarts it from
    // zero. The level flips on the edge where the count would complete. The
    // rise pulse is produced on that same edge, so it lines up with the new
    // level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end for the clock's set, up and down buttons. Each button is
// synchronized and debounced, and each press becomes one pulse. A held up or
// down button also produces auto-repeat pulses. If up and down are held
// together, both of those outputs are blocked.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous, active-high reset
//   btn_set_raw  - raw set button (high = pressed)
//   btn_up_raw   - raw up button
//   btn_down_raw - raw down button
//   set_pulse    - one-cycle pulse per set press; never repeats
//   up_pulse     - one-cycle pulse per up press, plus auto-repeats
//   down_pulse   - one-cycle pulse per down press, plus auto-repeats
// -----------------------------------------------------------------------------
module button_conditioner
    import clock_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_set_raw,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic set_pulse,
    output logic up_pulse,
    output logic down_pulse
);

    localparam bit               REPEAT_EN   = (REPEAT_DELAY != 0);
    localparam int               DELAY_EFF   = minSpacing(REPEAT_DELAY);
    localparam int               PERIOD_EFF  = minSpacing(REPEAT_PERIOD);
    localparam int               REP_MAX     = (DELAY_EFF > PERIOD_EFF) ? DELAY_EFF : PERIOD_EFF;
    localparam int               REP_W       = $clog2(REP_MAX) + 1;
    // The repeat counter reads 0 in the cycle of each emitted pulse. A repeat is
    // due when the counter sits one short of the spacing, so the output
    // register fires exactly DELAY_EFF or PERIOD_EFF cycles later.
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(DELAY_EFF - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(PERIOD_EFF - 1);

    logic          setLevel;
    logic          setRise;
    // Index 0 is up and index 1 is down.
    logic [1:0]    holdLevel;
    logic [1:0]    holdRise;
    logic          conflict;
    logic [1:0]    fire;

    repeat_state_e state_q [2];
    logic [REP_W-1:0] cnt_q [2];
    logic [1:0]    repeating_q;
    logic          setPulse_q;
    logic          upPulse_q;
    logic          downPulse_q;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_setDebounce (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btn_set_raw),
        .level_o (setLevel),
        .rise_o  (setRise)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_upDebounce (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btn_up_raw),
        .level_o (holdLevel[0]),
        .rise_o  (holdRise[0])
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_downDebounce (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (btn_down_raw),
        .level_o (holdLevel[1]),
        .rise_o  (holdRise[1])
    );

    assign conflict = holdLevel[0] & holdLevel[1];

    // A repeat is due when the counter reaches the current spacing. The first
    // repeat waits the delay, and later repeats wait the period. The button
    // must still be held and there must be no up/down conflict.
    always_comb begin
        fire = '0;
        for (int i = 0; i < 2; i++) begin
            if (REPEAT_EN && state_q[i] == HOLD && holdLevel[i] && !conflict) begin
                fire[i] = (cnt_q[i] == (repeating_q[i] ? PERIOD_LAST : DELAY_LAST));
            end
        end
    end

    // Both repeat FSMs and the three output registers. A conflict sends both
    // FSMs back to IDLE. A button still held after the conflict produces
    // nothing more: no new rise arrives until it is released and pressed
    // again. The set rise is qualified by its level, which is high whenever
    // the rise is.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            repeating_q <= '0;
            setPulse_q  <= 1'b0;
            upPulse_q   <= 1'b0;
            downPulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state_q[i] == IDLE) begin
                    if (REPEAT_EN && holdRise[i] && !conflict) begin
                        state_q[i]     <= HOLD;
                        cnt_q[i]       <= '0;
                        repeating_q[i] <= 1'b0;
                    end
                end else begin
                    if (!holdLevel[i] || conflict) begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                    end else if (fire[i]) begin
                        cnt_q[i]       <= '0;
                        repeating_q[i] <= 1'b1;
                    end else if (cnt_q[i] != '1) begin
                        cnt_q[i] <= cnt_q[i] + REP_W'(1);
                    end
                end
            end
            setPulse_q  <= setRise & setLevel;
            upPulse_q   <= !conflict && (holdRise[0] || fire[0]);
            downPulse_q <= !conflict && (holdRise[1] || fire[1]);
        end
    end

    assign set_pulse  = setPulse_q;
    assign up_pulse   = upPulse_q;
    assign down_pulse = downPulse_q;

endmodule
